// File: rtl/rk4_input_sequencer_pkg.sv
// Shared widths, FSM state encoding and latched-command layout for the RK4 input sequencer.
package rk4_pkg;

   localparam int DATA_W = 64;
   localparam int HOLD_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      RAMP = 2'd2,
      HOLD = 2'd3
   } state_t;

   typedef struct packed {
      logic signed [DATA_W-1:0] voltage;
      logic signed [DATA_W-1:0] load;
      logic        [DATA_W-1:0] slew;
      logic        [HOLD_W-1:0] hold;
   } rk4_cmd_t;

endpackage

// File: rtl/rk4_input_sequencer_if.sv
// Command handshake, step strobe and solver-facing outputs of the RK4 input sequencer.
interface rk4_input_sequencer_if;

   logic                              cmd_valid;
   logic                              cmd_ready;
   logic signed [rk4_pkg::DATA_W-1:0] cmd_voltage;
   logic signed [rk4_pkg::DATA_W-1:0] cmd_load;
   logic        [rk4_pkg::DATA_W-1:0] cmd_slew;
   logic        [rk4_pkg::HOLD_W-1:0] cmd_hold;
   logic                              abort;
   logic                              step_strobe;
   logic signed [rk4_pkg::DATA_W-1:0] voltage;
   logic signed [rk4_pkg::DATA_W-1:0] load;
   logic                              busy;
   logic                              done;

   modport master (
      output cmd_valid, cmd_voltage, cmd_load, cmd_slew, cmd_hold, abort, step_strobe,
      input  cmd_ready, voltage, load, busy, done
   );

   modport slave (
      input  cmd_valid, cmd_voltage, cmd_load, cmd_slew, cmd_hold, abort, step_strobe,
      output cmd_ready, voltage, load, busy, done
   );

endinterface

// File: rtl/rk4_input_sequencer_slew_step.sv
// One slew-limited step from cur toward tgt; arithmetic is one bit wider than the data
// so neither the difference nor a slew of 2^(W-1) or more can overflow.
module rk4_slew_step #(
   parameter int W = rk4_pkg::DATA_W
) (
   input  logic signed [W-1:0] i_cur,
   input  logic signed [W-1:0] i_tgt,
   input  logic        [W-1:0] i_slew,
   output logic signed [W-1:0] o_next,
   output logic                o_at_target
);

   logic [W:0] w_diff;
   logic [W:0] w_mag;
   logic [W:0] w_slew;
   logic [W:0] w_step;

   // Bit W of w_diff is the sign of (tgt - cur).
   always_comb begin
      w_diff = {i_tgt[W-1], i_tgt} - {i_cur[W-1], i_cur};
      w_mag  = w_diff[W] ? ({(W+1){1'b0}} - w_diff) : w_diff;
      w_slew = {1'b0, i_slew};
      w_step = {(W+1){1'b0}};
      if ((i_slew == {W{1'b0}}) || (w_mag <= w_slew)) begin
         o_next      = i_tgt;
         o_at_target = 1'b1;
      end else begin
         if (w_diff[W]) begin
            w_step = {i_cur[W-1], i_cur} - w_slew;
         end else begin
            w_step = {i_cur[W-1], i_cur} + w_slew;
         end
         o_next      = w_step[W-1:0];
         o_at_target = 1'b0;
      end
   end

endmodule

// File: rtl/rk4_input_sequencer.sv
// Queues one setpoint command at a time and drives the solver voltage/load inputs,
// changing them only on solver step boundaries.
module rk4_input_sequencer
   import rk4_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   rk4_input_sequencer_if.slave bus
);

   state_t                   r_state;
   rk4_cmd_t                 r_cmd;
   logic signed [DATA_W-1:0] r_voltage;
   logic signed [DATA_W-1:0] r_load;
   logic        [HOLD_W-1:0] r_hold_cnt;
   logic                     r_busy;
   logic                     r_done;

   logic signed [DATA_W-1:0] w_next;
   logic                     w_at_target;
   logic                     w_xfer;

   rk4_slew_step #(.W(DATA_W)) u_slew (
      .i_cur       (r_voltage),
      .i_tgt       (r_cmd.voltage),
      .i_slew      (r_cmd.slew),
      .o_next      (w_next),
      .o_at_target (w_at_target)
   );

   assign bus.cmd_ready = (r_state == IDLE) && !rst;
   assign w_xfer        = bus.cmd_valid && bus.cmd_ready;
   assign bus.voltage   = r_voltage;
   assign bus.load      = r_load;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;

   // Sequencer FSM; abort outranks a same-cycle strobe and leaves outputs where they are.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cmd      <= '0;
         r_voltage  <= {DATA_W{1'b0}};
         r_load     <= {DATA_W{1'b0}};
         r_hold_cnt <= {HOLD_W{1'b0}};
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_xfer) begin
                  r_cmd.voltage <= bus.cmd_voltage;
                  r_cmd.load    <= bus.cmd_load;
                  r_cmd.slew    <= bus.cmd_slew;
                  r_cmd.hold    <= bus.cmd_hold;
                  r_busy        <= 1'b1;
                  r_state       <= ARM;
               end else begin
                  r_state <= IDLE;
               end
            end
            ARM, RAMP: begin
               if (bus.abort) begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else if (bus.step_strobe) begin
                  r_voltage <= w_next;
                  if (r_state == ARM) begin
                     r_load <= r_cmd.load;
                  end else begin
                     r_load <= r_load;
                  end
                  if (w_at_target) begin
                     r_hold_cnt <= r_cmd.hold;
                     r_state    <= HOLD;
                  end else begin
                     r_state <= RAMP;
                  end
               end else begin
                  r_state <= r_state;
               end
            end
            HOLD: begin
               if (bus.abort) begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else if (bus.step_strobe) begin
                  if (r_hold_cnt == {HOLD_W{1'b0}}) begin
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= IDLE;
                  end else begin
                     r_hold_cnt <= r_hold_cnt - {{(HOLD_W-1){1'b0}}, 1'b1};
                  end
               end else begin
                  r_state <= HOLD;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/rk4_input_sequencer.md
Name: rk4_input_sequencer

Overview:
- Hardware stimulus source for the RK4 plant solver.
- Drives the solver's 64-bit signed `voltage` and `load` inputs from queued setpoint commands.
- Voltage is slew-rate limited; load is applied as a step. Both update only on solver step boundaries.
- Replaces testbench-only stimulus so closed-loop and on-target runs can drive the plant deterministically.

Parameters:
- DATA_W, 64, width of voltage/load/slew words, two's complement.
- HOLD_W, 32, width of the hold counter in solver steps.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_voltage  in  DATA_W  signed target voltage
- cmd_load  in  DATA_W  signed load setpoint
- cmd_slew  in  DATA_W  unsigned max voltage change per step; 0 = immediate
- cmd_hold  in  HOLD_W  steps to hold at target before done
- abort  in  1  cancel current command
- step_strobe  in  1  one-cycle pulse from solver: step completed, inputs may change
- voltage  out  DATA_W  to solver voltage input
- load  out  DATA_W  to solver load input
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at command completion

Behaviour:
- Reset: voltage=0, load=0, busy=0, done=0, cmd_ready=1, state IDLE, latched command cleared. Reset mid-ramp discards the command immediately.
- Handshake:
  - Transfer occurs when cmd_valid && cmd_ready at a rising edge.
  - cmd_ready = (state==IDLE) && !rst.
  - Command fields are registered on transfer; inputs are don't-care afterwards.
- FSM states: IDLE, ARM, RAMP, HOLD.
- IDLE:
  - On transfer, go to ARM; busy=1 from the next cycle.
  - A step_strobe in the same cycle as the transfer is ignored.
- ARM (wait for first step boundary):
  - On step_strobe: load <= cmd_load, and voltage takes its first slew step (rule below).
  - If voltage reaches target on that step, go to HOLD with hold_cnt=cmd_hold; else go to RAMP.
- RAMP, on each step_strobe:
  - diff = target - voltage, computed in DATA_W+1 bits signed (no overflow).
  - If slew==0 or |diff| <= slew: voltage <= target, go to HOLD with hold_cnt=cmd_hold.
  - Else voltage <= voltage + slew if diff>0, voltage - slew otherwise.
  - Slew is treated as DATA_W+1-bit unsigned, so slew >= 2^(DATA_W-1) never overflows.
- HOLD, on step_strobe:
  - If hold_cnt==0: done=1 for one cycle, go to IDLE.
  - Else hold_cnt decrements.
  - cmd_hold=0 therefore completes on the first strobe after the target is reached.
- Outputs change only on a cycle where step_strobe=1, except on reset.
  - Between strobes voltage/load are stable, so the solver sees constant inputs within an RK4 step.
- abort:
  - In ARM/RAMP/HOLD: go to IDLE next cycle; voltage/load keep current values; done not asserted; busy=0.
  - In IDLE: no effect.
  - abort has priority over a same-cycle step_strobe, which is then not applied.
- Back-to-back commands:
  - cmd_ready rises the cycle after done.
  - The new command starts from the current voltage (no return to 0).
- step_strobe asserted for consecutive cycles: each high cycle counts as one step.
- Latency:
  - Command to first output change = first step_strobe at least 1 cycle after transfer, plus 1 clock (registered output).
  - Total steps to done = ceil(|Vtgt - Vstart| / slew) (1 if slew=0 or already at target) + cmd_hold + 1.

Decomposition:
- Package rk4_pkg:
  - DATA_W, HOLD_W defaults.
  - typedef state_t enum {IDLE, ARM, RAMP, HOLD}.
  - typedef rk4_cmd_t struct {voltage, load, slew, hold}.
- One sub-module: rk4_slew_step.
  - Combinational DATA_W+1 compare/step unit: inputs cur, tgt, slew; outputs next, at_target.
  - Reused later for load slewing.

Test Plan:
- Reset then idle: rst high 3 cycles, 10 strobes, no command -> voltage=0, load=0, cmd_ready=1, busy=0, done never high.
- Ramp: cmd_voltage=100, slew=30, load=5, hold=2, strobes every 8 cycles -> voltage 30,60,90,100; load=5 from first strobe; done on the 7th strobe.
- Negative step with slew=0: from 100, cmd_voltage=-0x7FFF_FFFF_FFFF_FFFF, hold=0 -> voltage jumps to target on the first strobe; done on the second.
- Overflow guard: voltage=0x7FFF_FFFF_FFFF_FFFF, target=-0x8000_0000_0000_0000, slew=2^62 -> monotonic decrease, no wrap, exact final value, 3 ramp steps.
- Abort mid-ramp: target 100, slew 10; abort after the 4th strobe, coincident with a strobe -> voltage stays 40, done not asserted, cmd_ready=1 next cycle.
- Simultaneous events:
  - cmd transfer and strobe in the same cycle -> no output change that cycle; first update on the next strobe.
  - rst asserted during HOLD -> all outputs 0 on the next edge.
